// File: rtl/line_fetch_arbiter.sv
// Frame-memory arbiter: copies the next visible line into the scanline buffer during hblank
// and serves a req/ack drawing writer otherwise. Optional line doubling via LFA_DOUBLE_SCAN_EN.
module line_fetch_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int FETCH_WORDS = 80,
  parameter int LINE_STRIDE = 80,
  parameter int LB_AW       = 7
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              hblank,
  input  logic              newline,
  input  logic              vis_line,
  input  logic              frame_start,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic [LB_AW-1:0]  lb_addr,
  output logic [DATA_W-1:0] lb_data,
  output logic              busy,
  output logic              underrun
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  localparam logic [LB_AW-1:0]  LAST_IDX = LB_AW'(FETCH_WORDS - 1);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(LINE_STRIDE);

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] base_adv;
  logic [LB_AW-1:0]  idx;
  logic              hblank_d;
  logic              hblank_rise;
  logic              fetching;
  logic              start_fetch;
  logic              do_write;

  assign hblank_rise = hblank & ~hblank_d;
  assign fetching    = (state == FETCH) || (state == DRAIN);
  assign start_fetch = (state == IDLE) && hblank_rise && vis_line && !frame_start;
  assign do_write    = (state == IDLE) && !start_fetch && wr_req && !wr_ack;

`ifdef LFA_DOUBLE_SCAN_EN
  logic rpt;
  logic fetch_end;

  // A line ends (completed or cut off) unless frame_start overrides it.
  assign fetch_end = !frame_start && ((state == DRAIN) || (fetching && newline));

  always_ff @(posedge Clk) begin
    if (Rst || frame_start) rpt <= 1'b0;
    else if (fetch_end)     rpt <= ~rpt;
  end

  assign base_adv = rpt ? base + STRIDE : base;
`else
  assign base_adv = base + STRIDE;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      base      <= '0;
      idx       <= '0;
      hblank_d  <= 1'b0;
      wr_ack    <= 1'b0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      lb_we     <= 1'b0;
      lb_addr   <= '0;
      lb_data   <= '0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      hblank_d <= hblank;
      // NOTE: strobes default low every cycle so each is a single-cycle pulse unless re-asserted below.
      mem_re   <= 1'b0;
      mem_we   <= 1'b0;
      wr_ack   <= 1'b0;
      lb_we    <= 1'b0;

      if (do_write) begin
        mem_we    <= 1'b1;
        wr_ack    <= 1'b1;
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end

      if (frame_start) begin
        base     <= '0;
        underrun <= 1'b0;
        state    <= IDLE;
        busy     <= 1'b0;
      end else if (fetching && newline) begin
        state    <= IDLE;
        busy     <= 1'b0;
        underrun <= 1'b1;
        base     <= base_adv;
      end else begin
        unique case (state)
          IDLE: begin
            if (start_fetch) begin
              state    <= FETCH;
              busy     <= 1'b1;
              mem_re   <= 1'b1;
              mem_addr <= base;
              idx      <= '0;
            end
          end
          FETCH: begin
            // Read data for the word issued last cycle is on mem_rdata now.
            lb_we   <= 1'b1;
            lb_addr <= idx;
            lb_data <= mem_rdata;
            if (idx == LAST_IDX) begin
              state <= DRAIN;
            end else begin
              idx      <= idx + LB_AW'(1);
              mem_re   <= 1'b1;
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end
          DRAIN: begin
            state <= DONE;
            base  <= base_adv;
          end
          DONE: begin
            if (!hblank) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_fetch_arbiter.sv
// Directed bench for line_fetch_arbiter: fetch timing, writer handshake, underrun,
// frame_start priority and address wrap. Follows LFA_DOUBLE_SCAN_EN when defined.
module tb_line_fetch_arbiter;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        hblank, newline, vis_line, frame_start, wr_req;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic [15:0] mem_addr;
  logic        mem_re, mem_we;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        lb_we;
  logic [6:0]  lb_addr;
  logic [7:0]  lb_data;
  logic        busy, underrun;

  int checks   = 0;
  int failures = 0;

  logic [15:0] model_base;
  logic        model_rpt;

  line_fetch_arbiter dut (
    .Clk(Clk), .Rst(Rst), .hblank(hblank), .newline(newline), .vis_line(vis_line),
    .frame_start(frame_start), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_addr(lb_addr),
    .lb_data(lb_data), .busy(busy), .underrun(underrun)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Memory answers the registered read address; the arbiter captures it on the next edge.
  assign mem_rdata = mem_re ? pat(mem_addr) : 8'h00;

  task automatic model_advance();
`ifdef LFA_DOUBLE_SCAN_EN
    if (model_rpt) model_base = model_base + 16'd80;
    model_rpt = ~model_rpt;
`else
    model_base = model_base + 16'd80;
`endif
  endtask

  task automatic model_frame();
    model_base = 16'h0000;
    model_rpt  = 1'b0;
  endtask

  // Full 80-word fetch from the modelled base, ending back in IDLE with hblank low.
  task automatic run_fetch(input string name);
    logic [15:0] b, a;
    b = model_base;
    hblank = 1'b1;
    vis_line = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge Clk);
      a = b + 16'(i);
      checks++;
      if (mem_re !== 1'b1 || mem_addr !== a) begin
        failures++;
        $display("FAIL %s issue %0d: re=%b addr=%h, need re=1 addr=%h", name, i, mem_re, mem_addr, a);
      end
      checks++;
      if (wr_ack !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL %s ctl %0d: wr_ack=%b busy=%b, need 0/1", name, i, wr_ack, busy);
      end
      checks++;
      if (i == 0) begin
        if (lb_we !== 1'b0) begin
          failures++;
          $display("FAIL %s lb first: lb_we=%b, need 0", name, lb_we);
        end
      end else begin
        a = b + 16'(i - 1);
        if (lb_we !== 1'b1 || lb_addr !== 7'(i - 1) || lb_data !== pat(a)) begin
          failures++;
          $display("FAIL %s lb %0d: we=%b addr=%0d data=%h, need 1/%0d/%h",
                   name, i - 1, lb_we, lb_addr, lb_data, i - 1, pat(a));
        end
      end
    end
    @(negedge Clk);
    a = b + 16'd79;
    checks++;
    if (mem_re !== 1'b0 || lb_we !== 1'b1 || lb_addr !== 7'd79 || lb_data !== pat(a) || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s last word: re=%b we=%b addr=%0d data=%h busy=%b, need 0/1/79/%h/1",
               name, mem_re, lb_we, lb_addr, lb_data, busy, pat(a));
    end
    @(negedge Clk);
    checks++;
    if (lb_we !== 1'b0 || mem_re !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s done: we=%b re=%b busy=%b, need 0/0/1", name, lb_we, mem_re, busy);
    end
    model_advance();
    hblank = 1'b0;
    @(negedge Clk);
    checks++;
    if (busy !== 1'b0 || wr_ack !== 1'b0) begin
      failures++;
      $display("FAIL %s back to idle: busy=%b wr_ack=%b, need 0/0", name, busy, wr_ack);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; hblank = 1'b0; newline = 1'b0; vis_line = 1'b0; frame_start = 1'b0;
    wr_req = 1'b0; wr_addr = 16'h0; wr_data = 8'h0;
    model_frame();
    repeat (2) @(negedge Clk);
    checks++;
    if ({wr_ack, mem_re, mem_we, lb_we, busy, underrun} !== 6'b0 || mem_addr !== 16'h0 ||
        lb_addr !== 7'h0 || lb_data !== 8'h0 || mem_wdata !== 8'h0) begin
      failures++;
      $display("FAIL reset outputs: ack/re/we/lbwe/busy/und=%b addr=%h, need all 0",
               {wr_ack, mem_re, mem_we, lb_we, busy, underrun}, mem_addr);
    end
    Rst = 1'b0;
    @(negedge Clk);
    checks++;
    if (busy !== 1'b0 || mem_re !== 1'b0) begin
      failures++;
      $display("FAIL reset release: busy=%b re=%b, need 0/0", busy, mem_re);
    end
  endtask

  task automatic test_fetch();
    run_fetch("fetch_a");
    run_fetch("fetch_b");
  endtask

  task automatic test_write();
    wr_req = 1'b1; wr_addr = 16'h1234; wr_data = 8'hA5;
    @(negedge Clk);
    checks++;
    if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h1234 || mem_wdata !== 8'hA5) begin
      failures++;
      $display("FAIL write: ack=%b we=%b addr=%h data=%h, need 1/1/1234/a5", wr_ack, mem_we, mem_addr, mem_wdata);
    end
    wr_req = 1'b0;
    @(negedge Clk);
    checks++;
    if (wr_ack !== 1'b0 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL write end: ack=%b we=%b, need 0/0", wr_ack, mem_we);
    end
  endtask

  task automatic test_back_to_back();
    logic exp;
    wr_req = 1'b1; wr_addr = 16'h0400; wr_data = 8'h11;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      exp = (i % 2 == 0);
      checks++;
      if (wr_ack !== exp || mem_we !== exp) begin
        failures++;
        $display("FAIL b2b cycle %0d: ack=%b we=%b, need %b", i, wr_ack, mem_we, exp);
      end
    end
    wr_req = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_write_vs_fetch();
    wr_req = 1'b1; wr_addr = 16'h0BEE; wr_data = 8'h3C;
    run_fetch("fetch_vs_write");
    @(negedge Clk);
    checks++;
    if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0BEE || mem_wdata !== 8'h3C || underrun !== 1'b0) begin
      failures++;
      $display("FAIL delayed write: ack=%b we=%b addr=%h data=%h und=%b, need 1/1/0bee/3c/0",
               wr_ack, mem_we, mem_addr, mem_wdata, underrun);
    end
    wr_req = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_no_visible();
    hblank = 1'b1; vis_line = 1'b0;
    @(negedge Clk);
    checks++;
    if (busy !== 1'b0 || mem_re !== 1'b0) begin
      failures++;
      $display("FAIL invisible line: busy=%b re=%b, need 0/0", busy, mem_re);
    end
    hblank = 1'b0; vis_line = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_underrun();
    logic [15:0] a;
    a = model_base + 16'd39;
    hblank = 1'b1; vis_line = 1'b1;
    repeat (40) @(negedge Clk);
    checks++;
    if (mem_re !== 1'b1 || mem_addr !== a) begin
      failures++;
      $display("FAIL underrun pre: re=%b addr=%h, need 1/%h", mem_re, mem_addr, a);
    end
    newline = 1'b1;
    @(negedge Clk);
    newline = 1'b0; hblank = 1'b0;
    model_advance();
    checks++;
    if (underrun !== 1'b1 || mem_re !== 1'b0 || lb_we !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL underrun abort: und=%b re=%b lbwe=%b busy=%b, need 1/0/0/0", underrun, mem_re, lb_we, busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checks++;
      if (lb_we !== 1'b0 || mem_re !== 1'b0) begin
        failures++;
        $display("FAIL underrun quiet %0d: lbwe=%b re=%b, need 0/0", i, lb_we, mem_re);
      end
    end
    run_fetch("after_underrun");
    checks++;
    if (underrun !== 1'b1) begin
      failures++;
      $display("FAIL underrun sticky: und=%b, need 1", underrun);
    end
  endtask

  task automatic test_frame_start();
    hblank = 1'b1; vis_line = 1'b1; frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    model_frame();
    checks++;
    if (underrun !== 1'b0 || busy !== 1'b0 || mem_re !== 1'b0) begin
      failures++;
      $display("FAIL frame_start: und=%b busy=%b re=%b, need 0/0/0", underrun, busy, mem_re);
    end
    @(negedge Clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL frame_start held hblank: busy=%b, need 0", busy);
    end
    hblank = 1'b0;
    @(negedge Clk);
    run_fetch("after_frame_start");
  endtask

  task automatic test_double_scan();
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    model_frame();
    for (int i = 0; i < 4; i++) run_fetch($sformatf("scan_%0d", i));
  endtask

  task automatic test_wrap();
    int n;
`ifdef LFA_DOUBLE_SCAN_EN
    n = 1638;
`else
    n = 819;
`endif
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    model_frame();
    for (int i = 0; i < n; i++) begin
      hblank = 1'b1; vis_line = 1'b1;
      @(negedge Clk);
      newline = 1'b1;
      @(negedge Clk);
      newline = 1'b0; hblank = 1'b0;
      model_advance();
      @(negedge Clk);
    end
    checks++;
    if (underrun !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL wrap setup: und=%b busy=%b, need 1/0", underrun, busy);
    end
    run_fetch("wrap_line");
    run_fetch("post_wrap");
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write();
    test_back_to_back();
    test_write_vs_fetch();
    test_no_visible();
    test_underrun();
    test_frame_start();
    test_double_scan();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
